start_token_fifo: RTL and testbench



---
 rtl/start_token_fifo_pkg.sv | 44 ++++
 rtl/start_token_srl.sv | 46 ++++
 rtl/start_token_fifo.sv | 115 +++++++++++
 tb/tb_start_token_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/start_token_fifo_pkg.sv
// ---------------------------------------------------------------------------
// start_token_fifo_pkg
//   Shared definitions for the start-token FIFO: address-width helper,
//   counter width, the reset polarity of the status flags and the encoding
//   of the per-cycle FIFO operation.
// ---------------------------------------------------------------------------
package start_token_fifo_pkg;

  // Default storage address width and the matching occupancy counter width.
  // The counter needs one extra bit so that it can hold the value DEPTH.
  localparam int ADDR_WIDTH_DEFAULT = 3;
  localparam int CNT_WIDTH          = ADDR_WIDTH_DEFAULT + 1;

  // Status flag values driven while (and right after) reset is applied.
  localparam logic FULL_N_RESET  = 1'b1;
  localparam logic EMPTY_N_RESET = 1'b0;

  // Operation performed in a cycle, encoded as {pop, push}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Ceiling log2, used to validate ADDR_WIDTH against DEPTH.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Occupancy counter width for a given storage address width.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/start_token_srl.sv
// ---------------------------------------------------------------------------
// start_token_srl
//   DEPTH x DATA_WIDTH shift-register storage. On a write every slot moves
//   up by one and slot 0 takes din; the read port is a plain combinational
//   mux selected by addr. No reset: contents only matter below the
//   controller's occupancy count.
//
// Ports
//   clk   in   rising-edge clock
//   we    in   shift enable (qualified push from the controller)
//   addr  in   read address, ADDR_WIDTH bits
//   din   in   token shifted into slot 0
//   dout  out  storage[addr]
// ---------------------------------------------------------------------------
module start_token_srl
  import start_token_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Addresses at or above DEPTH only occur when the FIFO is empty (address
  // is don't-care then); return zero rather than reading past the array.
  assign dout = ({1'b0, addr} < DEPTH_A) ? mem[addr] : '0;

endmodule

// File: rtl/start_token_fifo.sv
// ---------------------------------------------------------------------------
// start_token_fifo
//   Start-token FIFO between two dataflow processes. Producer side uses a
//   full_n / write handshake, consumer side a first-word-fall-through
//   empty_n / read handshake. This module owns the occupancy counter, the
//   storage read address and the registered status flags; tokens live in a
//   shift-register array (start_token_srl).
//
// Ports
//   clk                in   rising-edge clock
//   reset              in   synchronous, active-high
//   if_full_n          out  registered, 1 = space available
//   if_write_ce        in   write clock-enable
//   if_write           in   write request
//   if_din             in   token to push
//   if_empty_n         out  registered, 1 = if_dout valid
//   if_read_ce         in   read clock-enable
//   if_read            in   read request (pop)
//   if_dout            out  head token, fall-through
//   if_num_data_valid  out  registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module start_token_fifo
  import start_token_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam int               CNT_W     = cnt_width(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT  = '0;

  if (ADDR_WIDTH != clog2(DEPTH) || DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH))
  begin : g_param_check
    $error("start_token_fifo: ADDR_WIDTH must equal clog2(DEPTH), DEPTH in 2..2**ADDR_WIDTH");
  end

  logic [CNT_W-1:0]      used;
  logic [CNT_W-1:0]      used_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  push;
  logic                  pop;
  fifo_op_e              op;

  // Requests are qualified only by the registered flags, so neither side
  // sees a combinational path from the other side's request.
  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read  & if_read_ce  & if_empty_n;
  assign op   = fifo_op_e'({pop, push});

  // Simultaneous push and pop keeps the count: the shift moves the
  // next-oldest token into slot used-1, which is exactly the new head.
  always_comb begin
    used_next = used;
    unique case (op)
      OP_PUSH: used_next = used + ONE_CNT;
      OP_POP:  used_next = used - ONE_CNT;
      default: used_next = used;
    endcase
  end

  // ---- registered state: counter and status flags from next-state count ----
  always_ff @(posedge clk) begin
    if (reset) begin
      used              <= ZERO_CNT;
      if_full_n         <= FULL_N_RESET;
      if_empty_n        <= EMPTY_N_RESET;
      if_num_data_valid <= ZERO_CNT;
    end else begin
      used              <= used_next;
      if_full_n         <= (used_next != DEPTH_CNT);
      if_empty_n        <= (used_next != ZERO_CNT);
      if_num_data_valid <= used_next;
    end
  end

  // Head token sits at slot used-1; when empty the wrapped address is unused.
  assign rd_addr = ADDR_WIDTH'(used - ONE_CNT);

  start_token_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

  // The counter must never wrap in either direction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && used == DEPTH_CNT));
      assert (!(pop && used == ZERO_CNT));
      assert (used <= DEPTH_CNT);
    end
  end

endmodule

// File: tb/tb_start_token_fifo.sv
// ---------------------------------------------------------------------------
// tb_start_token_fifo
//   Scoreboard bench for start_token_fifo (DEPTH=8, DATA_WIDTH=4). The
//   driver applies one set of inputs per cycle, advances a queue-based
//   reference FIFO and pushes the expected post-edge state; the monitor pops
//   and compares after each rising edge.
// ---------------------------------------------------------------------------
module tb_start_token_fifo;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_full_n;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_empty_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic [AW:0]   if_num_data_valid;

  always #5 clk = ~clk;

  start_token_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .if_full_n         (if_full_n),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_empty_n        (if_empty_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_num_data_valid (if_num_data_valid)
  );

  typedef struct {
    logic [AW:0]   cnt;
    logic          full_n;
    logic          empty_n;
    logic [DW-1:0] head;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model[$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // One cycle of stimulus; the reference FIFO follows the behavioural rules.
  task automatic step(input logic w, input logic wce, input logic [DW-1:0] d,
                      input logic r, input logic rce, input logic rst);
    exp_t e;
    bit   do_push;
    bit   do_pop;
    @(negedge clk);
    if_write    = w;
    if_write_ce = wce;
    if_din      = d;
    if_read     = r;
    if_read_ce  = rce;
    reset       = rst;
    if (rst) begin
      model.delete();
    end else begin
      do_push = w && wce && (model.size() < DEPTH);
      do_pop  = r && rce && (model.size() > 0);
      if (do_pop)  void'(model.pop_front());
      if (do_push) model.push_back(d);
    end
    e.cnt     = (AW+1)'(model.size());
    e.full_n  = (model.size() != DEPTH);
    e.empty_n = (model.size() != 0);
    e.head    = (model.size() > 0) ? model[0] : '0;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
  endtask

  task automatic push_tok(input logic [DW-1:0] d);
    step(1, 1, d, 0, 0, 0);
  endtask

  task automatic pop_tok();
    step(0, 0, '0, 1, 1, 0);
  endtask

  // Monitor: each expectation describes the state right after one edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",   32'(if_num_data_valid), 32'(e.cnt));
        chk("full_n",  32'(if_full_n),         32'(e.full_n));
        chk("empty_n", 32'(if_empty_n),        32'(e.empty_n));
        if (e.empty_n) chk("dout", 32'(if_dout), 32'(e.head));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    if_write    = 1'b0;
    if_write_ce = 1'b0;
    if_din      = '0;
    if_read     = 1'b0;
    if_read_ce  = 1'b0;

    // Reset held two cycles, then idle.
    step(0, 0, '0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 1);
    idle(2);

    // Reset wins over a simultaneous push.
    step(1, 1, 4'h5, 0, 0, 1);
    idle(1);

    // Fill 1..8, write 0xF while full (dropped), drain in order.
    for (int i = 1; i <= DEPTH; i++) push_tok(DW'(i));
    push_tok(4'hF);
    idle(1);
    for (int i = 0; i < DEPTH; i++) pop_tok();

    // Read at empty is ignored.
    pop_tok();
    pop_tok();

    // Simultaneous push and pop at count 3.
    push_tok(4'h5);
    push_tok(4'h6);
    push_tok(4'h7);
    step(1, 1, 4'h9, 1, 1, 0);
    for (int i = 0; i < 3; i++) pop_tok();

    // Push and pop at full: only the pop happens.
    for (int i = 0; i < DEPTH; i++) push_tok(DW'(i + 2));
    step(1, 1, 4'hE, 1, 1, 0);
    for (int i = 0; i < DEPTH - 1; i++) pop_tok();

    // Push and pop at empty: only the push happens.
    step(1, 1, 4'h2, 1, 1, 0);
    pop_tok();

    // Clock-enable masking.
    for (int i = 0; i < 4; i++) step(1, 0, 4'hA, 0, 0, 0);
    push_tok(4'h3);
    push_tok(4'h4);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0, 0);
    pop_tok();
    pop_tok();

    // Random soak; write bias alternates per block so full and empty are both hit.
    for (int blk = 0; blk < 10; blk++) begin
      int wp;
      wp = (blk % 2 == 0) ? 75 : 30;
      for (int i = 0; i < 1000; i++) begin
        step($urandom_range(0, 99) < wp,
             $urandom_range(0, 99) < 85,
             DW'($urandom),
             $urandom_range(0, 99) < (100 - wp),
             $urandom_range(0, 99) < 85,
             $urandom_range(0, 299) == 0);
      end
    end

    idle(1);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
